// File: rtl/cgra_load_sequencer_pkg.sv
// Shared types for the CGRA load sequencer: FSM states, error codes, memory map defaults.
package cgra_load_sequencer_pkg;

    localparam int DMEM_DEPTH_DEF = 1024;
    localparam int CMEM_DEPTH_DEF = 128;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_ADDR = 3'd1,
        S_GET_DATA = 3'd2,
        S_WRITE    = 3'd3,
        S_ARM      = 3'd4,
        S_EXEC     = 3'd5,
        S_DRAIN    = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_ADDR = 2'd1,
        ERR_SEQ  = 2'd2,
        ERR_TMO  = 2'd3
    } err_t;

    // The first error of a sequence is kept; later ones are dropped.
    function automatic err_t err_first(input err_t cur, input err_t nxt);
        return (cur == ERR_NONE) ? nxt : cur;
    endfunction

endpackage

// File: rtl/cgra_mem_decode.sv
// Purpose: map a global write address onto the DMEM or CMEM strobe and local address.
// Latency: purely combinational.
// Backpressure: none; strobes follow en directly.
module cgra_mem_decode #(
    parameter int DATA_W     = 16,
    parameter int DMEM_DEPTH = 1024,
    parameter int CMEM_DEPTH = 128
) (
    input  logic              en,
    input  logic [DATA_W-1:0] addr,
    output logic              dmem_we,
    output logic              cmem_we,
    output logic [DATA_W-1:0] local_addr,
    output logic              oor
);

    localparam logic [31:0] DMEM_LIM = 32'(DMEM_DEPTH);
    localparam logic [31:0] CMEM_LIM = 32'(DMEM_DEPTH + CMEM_DEPTH);

    logic [31:0] addr_w;
    assign addr_w = 32'(addr);

    always_comb begin
        dmem_we    = 1'b0;
        cmem_we    = 1'b0;
        local_addr = '0;
        oor        = 1'b0;
        if (addr_w < DMEM_LIM) begin
            dmem_we = en;
            if (en) local_addr = addr;
        end else if (addr_w < CMEM_LIM) begin
            cmem_we = en;
            if (en) local_addr = addr - DATA_W'(DMEM_DEPTH);
        end else begin
            oor = 1'b1;
        end
    end

endmodule

// File: rtl/cgra_load_sequencer.sv
// Purpose: load address/data pairs from a stream into DMEM/CMEM, then run and drain the CGRA.
// Latency: write strobe 1 cycle after the data-word handshake; DRAIN_CYC cycles after exec_end.
// Backpressure: s_ready only in GET_ADDR/GET_DATA; the stream stalls during write and exec.
module cgra_load_sequencer
    import cgra_load_sequencer_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int DMEM_DEPTH = DMEM_DEPTH_DEF,
    parameter int CMEM_DEPTH = CMEM_DEPTH_DEF,
    parameter int CNT_W      = 11,
    parameter int DRAIN_CYC  = 24,
    parameter int TMO_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  cfg_num_inst,
    input  logic [TMO_W-1:0]  cfg_timeout,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_is_addr,
    output logic              s_ready,
    output logic              dmem_we,
    output logic              cmem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              start_exec,
    input  logic              exec_end,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  loaded_cnt
);

    localparam logic [TMO_W-1:0] DRAIN_LAST = TMO_W'(DRAIN_CYC - 1);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [TMO_W-1:0]   cyc_q, cyc_d;
    err_t               err_q, err_d;
    logic               addr_oor;

    cgra_mem_decode #(
        .DATA_W     (DATA_W),
        .DMEM_DEPTH (DMEM_DEPTH),
        .CMEM_DEPTH (CMEM_DEPTH)
    ) u_mem_decode (
        .en         (state_q == S_WRITE),
        .addr       (addr_q),
        .dmem_we    (dmem_we),
        .cmem_we    (cmem_we),
        .local_addr (mem_addr),
        .oor        (addr_oor)
    );

    // Outputs decode straight from the state flop so reset drops them immediately.
    assign start_exec = (state_q == S_EXEC) || (state_q == S_DRAIN);
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign err        = (err_q != ERR_NONE);
    assign err_code   = err_q;
    assign loaded_cnt = cnt_q;
    assign mem_wdata  = data_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        cyc_d   = cyc_q;
        err_d   = err_q;
        s_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d   = ERR_NONE;
                    cnt_d   = '0;
                    num_d   = cfg_num_inst;
                    tmo_d   = cfg_timeout;
                    state_d = (cfg_num_inst == '0) ? S_ARM : S_GET_ADDR;
                end
            end
            S_GET_ADDR: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (s_is_addr) begin
                        addr_d  = s_data;
                        state_d = S_GET_DATA;
                    end else begin
                        err_d = err_first(err_q, ERR_SEQ);
                    end
                end
            end
            S_GET_DATA: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (!s_is_addr) begin
                        data_d  = s_data;
                        state_d = S_WRITE;
                    end else begin
                        addr_d = s_data;
                        err_d  = err_first(err_q, ERR_SEQ);
                    end
                end
            end
            S_WRITE: begin
                cnt_d = cnt_q + 1'b1;
                if (addr_oor) err_d = err_first(err_q, ERR_ADDR);
                state_d = (cnt_d == num_q) ? S_ARM : S_GET_ADDR;
            end
            S_ARM: begin
                cyc_d   = '0;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // cyc_d is the 1-based index of the current EXEC cycle; exec_end wins a tie.
                cyc_d = cyc_q + 1'b1;
                if (exec_end) begin
                    cyc_d   = '0;
                    state_d = S_DRAIN;
                end else if ((tmo_q != '0) && (cyc_d == tmo_q)) begin
                    cyc_d   = '0;
                    err_d   = err_first(err_q, ERR_TMO);
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == DRAIN_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            cyc_q   <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            cyc_q   <= cyc_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_cgra_load_sequencer.sv
// Bench for cgra_load_sequencer: directed and random load/exec sequences against a stream-level model.
module tb_cgra_load_sequencer;

    localparam int DRAIN = 24;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] cfg_num_inst;
    logic [31:0] cfg_timeout;
    logic        start, s_valid, s_is_addr, exec_end;
    logic [15:0] s_data;
    logic        s_ready, dmem_we, cmem_we, start_exec, busy, done, err;
    logic [15:0] mem_addr, mem_wdata;
    logic [1:0]  err_code;
    logic [10:0] loaded_cnt;

    always #5 clk = ~clk;

    cgra_load_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_num_inst (cfg_num_inst),
        .cfg_timeout  (cfg_timeout),
        .start        (start),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_is_addr    (s_is_addr),
        .s_ready      (s_ready),
        .dmem_we      (dmem_we),
        .cmem_we      (cmem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .start_exec   (start_exec),
        .exec_end     (exec_end),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_code     (err_code),
        .loaded_cnt   (loaded_cnt)
    );

    typedef struct packed {logic is_addr; logic [15:0] val;} word_t;
    typedef struct packed {logic is_c; logic [15:0] addr; logic [15:0] data;} wr_t;

    word_t wq[$];
    wr_t   exp_wr[$], obs_wr[$];
    int    exp_pair[$], obs_cyc[$], hs_q[$], pair_of[$];
    int    exp_err, exp_cnt;
    int    tests = 0, fails = 0;
    int    cyc = 0, se_cnt = 0, done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (start_exec) se_cnt++;
        if (done) done_cnt++;
        if (dmem_we || cmem_we) begin
            obs_wr.push_back({cmem_we, mem_addr, mem_wdata});
            obs_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void ws(input bit a, input int v);
        wq.push_back({a, 16'(v)});
    endfunction

    // Stream-level model: pairs an address with the next data word, maps it onto the memory map.
    function automatic void model();
        bit have;
        logic [15:0] a;
        int cnt;
        have = 0; a = '0; cnt = 0; exp_err = 0;
        exp_wr.delete(); exp_pair.delete(); pair_of.delete();
        foreach (wq[i]) begin
            pair_of.push_back(-1);
            if (wq[i].is_addr) begin
                if (have && exp_err == 0) exp_err = 2;
                a = wq[i].val;
                have = 1;
            end else if (!have) begin
                if (exp_err == 0) exp_err = 2;
            end else begin
                pair_of[i] = cnt;
                if (a < 16'd1024) begin
                    exp_wr.push_back({1'b0, a, wq[i].val}); exp_pair.push_back(cnt);
                end else if (a < 16'd1152) begin
                    exp_wr.push_back({1'b1, a - 16'd1024, wq[i].val}); exp_pair.push_back(cnt);
                end else if (exp_err == 0) begin
                    exp_err = 1;
                end
                cnt++;
                have = 0;
            end
        end
        exp_cnt = cnt;
    endfunction

    task automatic gen_stream(input int n);
        int cnt, picks[5];
        bit have, bad;
        word_t w;
        picks = '{0, 1023, 1024, 1151, 1152};
        cnt = 0; have = 0;
        wq.delete();
        while (cnt < n) begin
            bad = ($urandom_range(0, 9) == 0);
            w.is_addr = have ? bad : !bad;
            if (w.is_addr) begin
                case ($urandom_range(0, 5))
                    0: w.val = 16'($urandom_range(1152, 2100));
                    1: w.val = 16'(picks[$urandom_range(0, 4)]);
                    default: w.val = 16'($urandom_range(0, 1151));
                endcase
                have = 1;
            end else begin
                w.val = 16'($urandom);
                if (have) begin cnt++; have = 0; end
            end
            wq.push_back(w);
        end
    endtask

    task automatic send_word(input word_t w, input bit rec);
        bit ok;
        ok = 0;
        s_valid = 1'b1; s_is_addr = w.is_addr; s_data = w.val;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1;
                if (rec) hs_q.push_back(cyc);
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        chk("xfer", ok, 1);
    endtask

    // k >= 0: exec_end pulses k cycles after start_exec is seen; k < 0: exec_end never comes.
    task automatic run_seq(input int n, input int tmo, input int k);
        int len, fin_err;
        bit ok, tmo_hit;
        model();
        obs_wr.delete(); obs_cyc.delete(); hs_q.delete();
        se_cnt = 0; done_cnt = 0;
        cfg_num_inst = 11'(n); cfg_timeout = 32'(tmo);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        foreach (wq[i]) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_word(wq[i], pair_of[i] >= 0);
            if (i == 1) begin
                cfg_num_inst = 11'(n + 3);
                start = 1'b1; @(posedge clk); #1; start = 1'b0;
                cfg_num_inst = 11'(n);
            end
        end
        ok = 0;
        for (int t = 0; t < 100 && !ok; t++) begin @(negedge clk); ok = start_exec; end
        chk("exec_rise", ok, 1);
        if (!ok) return;
        tmo_hit = (tmo != 0) && (k < 0 || tmo < k + 1);
        len     = tmo_hit ? tmo : k + 1;
        fin_err = (exp_err != 0) ? exp_err : (tmo_hit ? 3 : 0);
        if (k >= 0) begin
            repeat (k) @(posedge clk);
            #1; exec_end = 1'b1;
            @(posedge clk); #1; exec_end = 1'b0;
        end else begin
            repeat (tmo - 1) @(negedge clk);
            chk("tmo_before", err_code, exp_err);
            @(negedge clk);
            chk("tmo_at", err_code, fin_err);
            chk("tmo_drain", start_exec, 1);
        end
        ok = 0;
        for (int t = 0; t < 200 && !ok; t++) begin @(negedge clk); ok = done; end
        chk("done_seen", ok, 1);
        repeat (2) @(negedge clk);
        chk("done_cnt", done_cnt, 1);
        chk("exec_len", se_cnt, len + DRAIN);
        chk("loaded", loaded_cnt, exp_cnt);
        chk("err_code", err_code, fin_err);
        chk("err", err, fin_err != 0);
        chk("busy_end", busy, 0);
        chk("n_writes", obs_wr.size(), exp_wr.size());
        foreach (exp_wr[i]) begin
            if (i < obs_wr.size() && exp_pair[i] < hs_q.size()) begin
                chk("wr", obs_wr[i], exp_wr[i]);
                chk("wr_lat", obs_cyc[i], hs_q[exp_pair[i]] + 1);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n, k, sel, tmo;
        rst_n = 1'b0; cfg_num_inst = '0; cfg_timeout = '0; start = 1'b0;
        s_valid = 1'b0; s_is_addr = 1'b0; s_data = '0; exec_end = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", s_ready, 0);
        chk("rst_exec", start_exec, 0);
        chk("rst_we", {dmem_we, cmem_we}, 0);
        chk("rst_done", done, 0);
        chk("rst_err", {err, err_code}, 0);
        chk("rst_cnt", loaded_cnt, 0);
        chk("rst_bus", {mem_addr, mem_wdata}, 0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;

        // Stream words offered while idle must not transfer.
        s_valid = 1'b1; s_is_addr = 1'b1; s_data = 16'd3;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ready", s_ready, 0);
            chk("idle_busy", busy, 0);
        end
        @(posedge clk); #1; s_valid = 1'b0;

        wq.delete(); ws(1, 5); ws(0, 'hBEEF); ws(1, 1030); ws(0, 'h1234);
        run_seq(2, 0, 10);

        wq.delete(); ws(1, 2000); ws(0, 'hAAAA); ws(1, 1151); ws(0, 'h5555); ws(1, 1152); ws(0, 'h6666);
        run_seq(3, 0, 3);

        wq.delete(); ws(1, 3); ws(0, 'h1111); ws(0, 'h2222); ws(1, 4); ws(0, 'h3333);
        run_seq(2, 0, 0);

        wq.delete(); ws(1, 10); ws(1, 20); ws(0, 'h7777);
        run_seq(1, 0, 2);

        wq.delete(); ws(1, 1023); ws(0, 'h0102); ws(1, 1024); ws(0, 'h0304);
        run_seq(2, 1000, 5);

        wq.delete();
        run_seq(0, 50, -1);

        for (int r = 0; r < 8; r++) begin
            n   = $urandom_range(0, 6);
            k   = $urandom_range(0, 20);
            sel = $urandom_range(0, 2);
            tmo = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(1, 25) : 1000;
            gen_stream(n);
            run_seq(n, tmo, k);
        end

        // Reset while the write strobe is up.
        cfg_num_inst = 11'd1; cfg_timeout = '0;
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        send_word({1'b1, 16'd8}, 0);
        send_word({1'b0, 16'h00AA}, 0);
        chk("wr_now", {dmem_we, cmem_we, mem_addr, mem_wdata}, {1'b1, 1'b0, 16'd8, 16'h00AA});
        rst_n = 1'b0; #1;
        chk("rst_wr_we", {dmem_we, cmem_we}, 0);
        chk("rst_wr_busy", busy, 0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Reset while executing.
        cfg_num_inst = 11'd1;
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        send_word({1'b1, 16'd9}, 0);
        send_word({1'b0, 16'h0001}, 0);
        ok = 0;
        for (int t = 0; t < 50 && !ok; t++) begin @(negedge clk); ok = start_exec; end
        chk("rst_ex_rise", ok, 1);
        chk("rst_ex_cnt_pre", loaded_cnt, 1);
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b0; #1;
        chk("rst_ex_exec", start_exec, 0);
        chk("rst_ex_busy", busy, 0);
        chk("rst_ex_cnt", loaded_cnt, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        wq.delete();
        run_seq(0, 0, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cgra_load_sequencer.md
CGRA_LOAD_SEQUENCER -- requirements
Module: cgra_load_sequencer

Interface
REQ-001 Parameters SHALL be as follows.
- DATA_W, 16: memory word width.
- DMEM_DEPTH, 1024: DMEM words; addresses 0..1023.
- CMEM_DEPTH, 128: CMEM words; addresses 1024..1151.
- CNT_W, 11: width of the load-count register.
- DRAIN_CYC, 24: cycles held in DRAIN after exec_end.
- TMO_W, 32: width of the execution timeout counter.

REQ-002 Ports SHALL be as follows (name, direction, width, meaning).
- clk, in, 1: single clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- cfg_num_inst, in, CNT_W: number of address/data pairs to load; sampled on start.
- cfg_timeout, in, TMO_W: exec cycle limit; 0 disables the limit; sampled on start.
- start, in, 1: one-cycle pulse that begins a load and exec sequence.
- s_valid, in, 1: stream word valid.
- s_data, in, DATA_W: stream word.
- s_is_addr, in, 1: 1 marks an address word, 0 marks a data word.
- s_ready, out, 1: stream ready.
- dmem_we, out, 1: DMEM write strobe.
- cmem_we, out, 1: CMEM write strobe.
- mem_addr, out, DATA_W: write address, local to the selected memory.
- mem_wdata, out, DATA_W: write data.
- start_exec, out, 1: level that enables the CGRA.
- exec_end, in, 1: CGRA completion; may be a level or a pulse.
- busy, out, 1: high in every state except IDLE and DONE.
- done, out, 1: one-cycle pulse on entering DONE.
- err, out, 1: sticky error flag, cleared by start.
- err_code, out, 2: 0 none, 1 address out of range, 2 sequence error, 3 timeout.
- loaded_cnt, out, CNT_W: pairs written so far.

Function
REQ-003 The FSM states SHALL be IDLE, GET_ADDR, GET_DATA, WRITE, ARM, EXEC, DRAIN, DONE.
REQ-004 In IDLE, start SHALL clear err, err_code and loaded_cnt and latch both cfg inputs. It SHALL then go to GET_ADDR, or to ARM if cfg_num_inst==0.
REQ-005 s_ready SHALL be 1 only in GET_ADDR and GET_DATA; a word transfers when s_valid and s_ready are both 1.
REQ-006 In GET_ADDR, a transfer with s_is_addr=1 SHALL latch the address and go to GET_DATA. A transfer with s_is_addr=0 SHALL set err_code=2, be discarded, and leave the state unchanged.
REQ-007 In GET_DATA, a transfer with s_is_addr=0 SHALL latch the data and go to WRITE. A transfer with s_is_addr=1 SHALL set err_code=2 and replace the latched address.
REQ-008 WRITE SHALL last exactly one cycle and assert at most one strobe.
- addr<DMEM_DEPTH: dmem_we=1 with mem_addr=addr.
- DMEM_DEPTH<=addr<DMEM_DEPTH+CMEM_DEPTH: cmem_we=1 with mem_addr=addr-DMEM_DEPTH.
- Otherwise: no strobe, err_code=1. The pair still counts.
REQ-009 Write latency from the data-word handshake to the strobe SHALL be exactly 1 cycle.
REQ-010 WRITE SHALL increment loaded_cnt. It SHALL then go to ARM if the new loaded_cnt equals the latched cfg_num_inst, otherwise to GET_ADDR.
REQ-011 ARM SHALL last one cycle; start_exec SHALL rise on entry to EXEC and stay 1 through EXEC and DRAIN.
REQ-012 EXEC SHALL wait for exec_end==1 and then go to DRAIN. exec_end sampled in the first EXEC cycle SHALL be honoured.
REQ-013 EXEC SHALL count cycles from 1. If the latched timeout is nonzero and the count reaches it without exec_end, err_code SHALL become 3 and the FSM SHALL go to DRAIN.
REQ-014 DRAIN SHALL last exactly DRAIN_CYC cycles. start_exec SHALL then fall, and the FSM SHALL enter DONE for one cycle (done=1) and return to IDLE.
REQ-015 start SHALL be ignored in every state except IDLE.
REQ-016 err SHALL equal (err_code!=0). The first error code SHALL be held and later errors SHALL NOT overwrite it.
REQ-017 No stream transfer SHALL occur outside GET_ADDR and GET_DATA.

Reset
REQ-018 On rst_n low, asynchronously:
- state SHALL become IDLE.
- All outputs, counters and latches SHALL become 0.
- start_exec, dmem_we and cmem_we SHALL drop immediately, including when reset asserts mid-load or mid-exec.
REQ-019 After rst_n rises, the block SHALL take no action until a start pulse.

Structure
REQ-020 The shared package SHALL hold the state enum, the err_code enum, and the DMEM_DEPTH and CMEM_DEPTH defaults.
REQ-021 A single sub-module, cgra_mem_decode (combinational address-to-strobe and local-address decode), SHALL be instantiated; everything else SHALL be flat.

Verification
REQ-022 cfg_num_inst=2; stream (A 5, D 0xBEEF, A 1030, D 0x1234) -> dmem_we at addr 5 with 0xBEEF, then cmem_we at addr 6 with 0x1234; each strobe 1 cycle after its data handshake; loaded_cnt=2.
REQ-023 Continuing REQ-022 with exec_end pulsed 10 cycles after start_exec rises -> start_exec high for 10+1+24 cycles, done pulses once, err=0.
REQ-024 Address 2000 in a pair -> no write strobe, err_code=1, sequence completes normally.
REQ-025 Two data words in a row after an address -> err_code=2; only the first pair is written.
REQ-026 cfg_timeout=50, exec_end held 0 -> err_code=3 at EXEC cycle 50, then DRAIN 24 cycles, then done.
REQ-027 rst_n pulsed low during EXEC -> start_exec=0 in the same cycle, state IDLE; a new start runs cleanly with cfg_num_inst=0 (ARM directly).
